// File: rtl/xbar_rtn_rob_if.sv
// Bundle of the allocation, bank-return and in-order drain signals of the
// crossbar return reorder buffer.
interface xbar_rtn_rob_if #(
    parameter int CH_NUM    = 4,
    parameter int ROB_DEPTH = 8,
    parameter int DATA_W    = 128
);
    localparam int CH_W  = $clog2(CH_NUM);
    localparam int ROB_W = $clog2(ROB_DEPTH);

    logic [CH_NUM-1:0]        ch_alloc_valid_i;
    logic [CH_NUM-1:0]        ch_alloc_ready_o;
    logic [CH_NUM*ROB_W-1:0]  ch_alloc_rob_num_o;

    logic                     sc_xbar_valid_i;
    logic                     sc_xbar_ready_o;
    logic [CH_W-1:0]          sc_xbar_channel_id_i;
    logic [ROB_W-1:0]         sc_xbar_rob_num_i;
    logic [DATA_W-1:0]        sc_xbar_data_i;

    logic [CH_NUM-1:0]        xbar_ch_rtn_valid_o;
    logic [CH_NUM-1:0]        xbar_ch_rtn_ready_i;
    logic [CH_NUM*DATA_W-1:0] xbar_ch_rtn_data_o;

    logic                     rob_err_o;

    modport master (
        output ch_alloc_valid_i,
        input  ch_alloc_ready_o,
        input  ch_alloc_rob_num_o,
        output sc_xbar_valid_i,
        input  sc_xbar_ready_o,
        output sc_xbar_channel_id_i,
        output sc_xbar_rob_num_i,
        output sc_xbar_data_i,
        input  xbar_ch_rtn_valid_o,
        output xbar_ch_rtn_ready_i,
        input  xbar_ch_rtn_data_o,
        input  rob_err_o
    );

    modport slave (
        input  ch_alloc_valid_i,
        output ch_alloc_ready_o,
        output ch_alloc_rob_num_o,
        input  sc_xbar_valid_i,
        output sc_xbar_ready_o,
        input  sc_xbar_channel_id_i,
        input  sc_xbar_rob_num_i,
        input  sc_xbar_data_i,
        output xbar_ch_rtn_valid_o,
        input  xbar_ch_rtn_ready_i,
        output xbar_ch_rtn_data_o,
        output rob_err_o
    );
endinterface

// File: rtl/xbar_rtn_rob.sv
// Per-channel return reorder buffer: bank returns arrive tagged in any order
// and are released to each crossbar channel strictly in allocation order.
module xbar_rtn_rob #(
    parameter int CH_NUM    = 4,
    parameter int ROB_DEPTH = 8,
    parameter int DATA_W    = 128
) (
    input logic           clk_i,
    input logic           rst_i,
    xbar_rtn_rob_if.slave bus
);
    localparam int CH_W  = $clog2(CH_NUM);
    localparam int ROB_W = $clog2(ROB_DEPTH);
    localparam logic [ROB_W:0] FULL_CNT = (ROB_W + 1)'(ROB_DEPTH);

    logic [ROB_W-1:0]     alloc_ptr [CH_NUM];
    logic [ROB_W-1:0]     ret_ptr   [CH_NUM];
    logic [ROB_W:0]       cnt       [CH_NUM];
    logic [ROB_DEPTH-1:0] busy      [CH_NUM];
    logic [ROB_DEPTH-1:0] done      [CH_NUM];
    logic [DATA_W-1:0]    mem       [CH_NUM][ROB_DEPTH];

    logic                 sc_ready_q;
    logic                 rob_err_q;

    logic [CH_W-1:0]      fill_ch;
    logic [ROB_W-1:0]     fill_slot;
    logic                 fill_req;
    logic                 fill_ok;
    logic [CH_NUM-1:0]    alloc_fire;
    logic [CH_NUM-1:0]    drain_fire;

    assign fill_ch   = bus.sc_xbar_channel_id_i;
    assign fill_slot = bus.sc_xbar_rob_num_i;

    // A fill is legal only into a slot that is allocated and not yet written;
    // this also rejects a fill aimed at the head slot while it is retiring.
    always_comb begin
        fill_req   = bus.sc_xbar_valid_i && sc_ready_q;
        fill_ok    = fill_req && busy[fill_ch][fill_slot] && !done[fill_ch][fill_slot];
        alloc_fire = '0;
        drain_fire = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            alloc_fire[c] = bus.ch_alloc_valid_i[c] && (cnt[c] != FULL_CNT);
            drain_fire[c] = done[c][ret_ptr[c]] && bus.xbar_ch_rtn_ready_i[c];
        end
    end

    always_comb begin
        bus.ch_alloc_ready_o    = '0;
        bus.ch_alloc_rob_num_o  = '0;
        bus.xbar_ch_rtn_valid_o = '0;
        bus.xbar_ch_rtn_data_o  = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            bus.ch_alloc_ready_o[c]                       = (cnt[c] != FULL_CNT);
            bus.ch_alloc_rob_num_o[c*ROB_W +: ROB_W]      = alloc_ptr[c];
            bus.xbar_ch_rtn_valid_o[c]                    = done[c][ret_ptr[c]];
            bus.xbar_ch_rtn_data_o[c*DATA_W +: DATA_W]    = mem[c][ret_ptr[c]];
        end
    end

    assign bus.sc_xbar_ready_o = sc_ready_q;
    assign bus.rob_err_o       = rob_err_q;

    // Alloc and retire can only hit the same slot when the channel is empty
    // or full, and in both cases one of them is blocked, so the bit updates
    // below never collide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sc_ready_q <= 1'b0;
            rob_err_q  <= 1'b0;
            for (int c = 0; c < CH_NUM; c++) begin
                alloc_ptr[c] <= '0;
                ret_ptr[c]   <= '0;
                cnt[c]       <= '0;
                busy[c]      <= '0;
                done[c]      <= '0;
            end
        end else begin
            sc_ready_q <= 1'b1;
            if (fill_req && !fill_ok) begin
                rob_err_q <= 1'b1;
            end
            for (int c = 0; c < CH_NUM; c++) begin
                if (alloc_fire[c]) begin
                    busy[c][alloc_ptr[c]] <= 1'b1;
                    alloc_ptr[c]          <= alloc_ptr[c] + 1'b1;
                end
                if (drain_fire[c]) begin
                    busy[c][ret_ptr[c]] <= 1'b0;
                    done[c][ret_ptr[c]] <= 1'b0;
                    ret_ptr[c]          <= ret_ptr[c] + 1'b1;
                end
                case ({alloc_fire[c], drain_fire[c]})
                    2'b10:   cnt[c] <= cnt[c] + 1'b1;
                    2'b01:   cnt[c] <= cnt[c] - 1'b1;
                    default: cnt[c] <= cnt[c];
                endcase
            end
            if (fill_ok) begin
                done[fill_ch][fill_slot] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && fill_ok) begin
            mem[fill_ch][fill_slot] <= bus.sc_xbar_data_i;
        end
    end
endmodule

// File: tb/tb_xbar_rtn_rob.sv
// Directed bench for xbar_rtn_rob: hand-computed expectations for in-order
// release, out-of-order fills, full/wrap, channel independence and errors.
module tb_xbar_rtn_rob;
    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    xbar_rtn_rob_if bus ();

    xbar_rtn_rob dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one cycle of stimulus, clock it in, then return inputs to idle.
    task automatic applyStimulus(input logic [3:0] alloc, input logic [3:0] rdy,
                                 input logic fill, input logic [1:0] ch,
                                 input logic [2:0] rob, input logic [127:0] data);
        bus.ch_alloc_valid_i    = alloc;
        bus.xbar_ch_rtn_ready_i = rdy;
        bus.sc_xbar_valid_i     = fill;
        bus.sc_xbar_channel_id_i = ch;
        bus.sc_xbar_rob_num_i   = rob;
        bus.sc_xbar_data_i      = data;
        tick();
        bus.ch_alloc_valid_i    = 4'h0;
        bus.xbar_ch_rtn_ready_i = 4'h0;
        bus.sc_xbar_valid_i     = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(4'h0, 4'h0, 1'b0, 2'd0, 3'd0, 128'h0);
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        idleCycle();
        checkOutput("rst_alloc_ready", bus.ch_alloc_ready_o, 4'hF);
        checkOutput("rst_rob_num", bus.ch_alloc_rob_num_o, 12'h000);
        checkOutput("rst_rtn_valid", bus.xbar_ch_rtn_valid_o, 4'h0);
        checkOutput("rst_err", bus.rob_err_o, 1'b0);
        checkOutput("rst_sc_ready", bus.sc_xbar_ready_o, 1'b0);
        rst_i = 1'b0;
        idleCycle();
        checkOutput("post_rst_sc_ready", bus.sc_xbar_ready_o, 1'b1);
    endtask

    function automatic logic [127:0] rtnData(input int c);
        return bus.xbar_ch_rtn_data_o[c*128 +: 128];
    endfunction

    function automatic logic [2:0] robNum(input int c);
        return bus.ch_alloc_rob_num_o[c*3 +: 3];
    endfunction

    logic [127:0] expQ [8];

    initial begin
        rst_i = 1'b1;
        bus.ch_alloc_valid_i     = 4'h0;
        bus.xbar_ch_rtn_ready_i  = 4'h0;
        bus.sc_xbar_valid_i      = 1'b0;
        bus.sc_xbar_channel_id_i = 2'd0;
        bus.sc_xbar_rob_num_i    = 3'd0;
        bus.sc_xbar_data_i       = 128'h0;
        doReset();

        // Single entry on channel 0
        checkOutput("t1_rob_num_before", robNum(0), 3'd0);
        applyStimulus(4'b0001, 4'h0, 1'b0, 2'd0, 3'd0, 128'h0);
        checkOutput("t1_rob_num_after", robNum(0), 3'd1);
        checkOutput("t1_valid_unfilled", bus.xbar_ch_rtn_valid_o, 4'h0);
        applyStimulus(4'h0, 4'h0, 1'b1, 2'd0, 3'd0, {16{8'hA5}});
        checkOutput("t1_valid", bus.xbar_ch_rtn_valid_o, 4'b0001);
        checkOutput("t1_data", rtnData(0), {16{8'hA5}});
        applyStimulus(4'h0, 4'b0001, 1'b0, 2'd0, 3'd0, 128'h0);
        checkOutput("t1_valid_drained", bus.xbar_ch_rtn_valid_o, 4'h0);
        checkOutput("t1_alloc_ready", bus.ch_alloc_ready_o, 4'hF);

        // Out-of-order fills on channel 1
        for (int i = 0; i < 4; i++) applyStimulus(4'b0010, 4'h0, 1'b0, 2'd0, 3'd0, 128'h0);
        checkOutput("t2_rob_num", robNum(1), 3'd4);
        applyStimulus(4'h0, 4'b0010, 1'b1, 2'd1, 3'd3, 128'd3);
        checkOutput("t2_hold_r3", bus.xbar_ch_rtn_valid_o[1], 1'b0);
        applyStimulus(4'h0, 4'b0010, 1'b1, 2'd1, 3'd1, 128'd1);
        checkOutput("t2_hold_r1", bus.xbar_ch_rtn_valid_o[1], 1'b0);
        applyStimulus(4'h0, 4'b0010, 1'b1, 2'd1, 3'd2, 128'd2);
        checkOutput("t2_hold_r2", bus.xbar_ch_rtn_valid_o[1], 1'b0);
        applyStimulus(4'h0, 4'h0, 1'b1, 2'd1, 3'd0, 128'd0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t2_valid_%0d", k), bus.xbar_ch_rtn_valid_o[1], 1'b1);
            checkOutput($sformatf("t2_data_%0d", k), rtnData(1), 128'(k));
            applyStimulus(4'h0, 4'b0010, 1'b0, 2'd0, 3'd0, 128'h0);
        end
        checkOutput("t2_empty", bus.xbar_ch_rtn_valid_o[1], 1'b0);

        // Full, no bypass, counter rule and wrap on channel 2
        for (int i = 0; i < 8; i++) applyStimulus(4'b0100, 4'h0, 1'b0, 2'd0, 3'd0, 128'h0);
        checkOutput("t3_full", bus.ch_alloc_ready_o[2], 1'b0);
        checkOutput("t3_wrap_num", robNum(2), 3'd0);
        for (int i = 0; i < 8; i++)
            applyStimulus(4'h0, 4'h0, 1'b1, 2'd2, 3'(i), 128'h200 + 128'(i));
        checkOutput("t3_head_data", rtnData(2), 128'h200);
        applyStimulus(4'b0100, 4'b0100, 1'b0, 2'd0, 3'd0, 128'h0);
        checkOutput("t3_ready_after_drain", bus.ch_alloc_ready_o[2], 1'b1);
        checkOutput("t3_no_bypass_num", robNum(2), 3'd0);
        applyStimulus(4'b0100, 4'b0100, 1'b0, 2'd0, 3'd0, 128'h0);
        checkOutput("t3_same_cycle_num", robNum(2), 3'd1);
        checkOutput("t3_same_cycle_ready", bus.ch_alloc_ready_o[2], 1'b1);
        applyStimulus(4'b0100, 4'h0, 1'b0, 2'd0, 3'd0, 128'h0);
        checkOutput("t3_full_again", bus.ch_alloc_ready_o[2], 1'b0);
        checkOutput("t3_num_2", robNum(2), 3'd2);
        applyStimulus(4'h0, 4'h0, 1'b1, 2'd2, 3'd1, 128'h301);
        applyStimulus(4'h0, 4'h0, 1'b1, 2'd2, 3'd0, 128'h300);
        for (int i = 0; i < 6; i++) expQ[i] = 128'h202 + 128'(i);
        expQ[6] = 128'h300;
        expQ[7] = 128'h301;
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("t3_valid_%0d", k), bus.xbar_ch_rtn_valid_o[2], 1'b1);
            checkOutput($sformatf("t3_data_%0d", k), rtnData(2), expQ[k]);
            applyStimulus(4'h0, 4'b0100, 1'b0, 2'd0, 3'd0, 128'h0);
        end
        checkOutput("t3_empty", bus.xbar_ch_rtn_valid_o[2], 1'b0);

        // Channel 3 stalls with two done entries while channel 0 runs
        applyStimulus(4'b1000, 4'h0, 1'b0, 2'd0, 3'd0, 128'h0);
        applyStimulus(4'b1000, 4'h0, 1'b1, 2'd3, 3'd0, 128'hC0);
        applyStimulus(4'h0, 4'h0, 1'b1, 2'd3, 3'd1, 128'hC1);
        for (int i = 0; i < 4; i++) applyStimulus(4'b0001, 4'h0, 1'b0, 2'd0, 3'd0, 128'h0);
        checkOutput("t4_ch0_num", robNum(0), 3'd5);
        for (int i = 0; i < 4; i++)
            applyStimulus(4'h0, 4'h0, 1'b1, 2'd0, 3'(i + 1), 128'hB0 + 128'(i));
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t4_ch0_data_%0d", k), rtnData(0), 128'hB0 + 128'(k));
            applyStimulus(4'h0, 4'b0001, 1'b0, 2'd0, 3'd0, 128'h0);
        end
        checkOutput("t4_valids", bus.xbar_ch_rtn_valid_o, 4'b1000);
        checkOutput("t4_ch3_data", rtnData(3), 128'hC0);
        checkOutput("t4_err_clean", bus.rob_err_o, 1'b0);

        // Protocol errors
        doReset();
        applyStimulus(4'h0, 4'h0, 1'b1, 2'd0, 3'd5, 128'hDEAD);
        checkOutput("t5_err_unalloc", bus.rob_err_o, 1'b1);
        checkOutput("t5_no_valid", bus.xbar_ch_rtn_valid_o, 4'h0);
        applyStimulus(4'b0001, 4'h0, 1'b0, 2'd0, 3'd0, 128'h0);
        applyStimulus(4'h0, 4'h0, 1'b1, 2'd0, 3'd0, 128'h11);
        applyStimulus(4'h0, 4'h0, 1'b1, 2'd0, 3'd0, 128'h22);
        checkOutput("t5_err_sticky", bus.rob_err_o, 1'b1);
        checkOutput("t5_first_data", rtnData(0), 128'h11);
        applyStimulus(4'h0, 4'b0001, 1'b0, 2'd0, 3'd0, 128'h0);
        checkOutput("t5_drained", bus.xbar_ch_rtn_valid_o[0], 1'b0);

        // Reset mid-flight discards channel 1 state
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(4'b0010, 4'h0, 1'b0, 2'd0, 3'd0, 128'h0);
        applyStimulus(4'h0, 4'h0, 1'b1, 2'd1, 3'd0, 128'h77);
        checkOutput("t6_valid_before", bus.xbar_ch_rtn_valid_o[1], 1'b1);
        applyStimulus(4'h0, 4'h0, 1'b1, 2'd0, 3'd7, 128'h0);
        checkOutput("t6_err_before", bus.rob_err_o, 1'b1);
        rst_i = 1'b1;
        applyStimulus(4'b0010, 4'b0010, 1'b1, 2'd1, 3'd1, 128'h88);
        rst_i = 1'b0;
        checkOutput("t6_valids", bus.xbar_ch_rtn_valid_o, 4'h0);
        checkOutput("t6_rob_num1", robNum(1), 3'd0);
        checkOutput("t6_alloc_ready", bus.ch_alloc_ready_o, 4'hF);
        checkOutput("t6_err", bus.rob_err_o, 1'b0);
        idleCycle();
        checkOutput("t6_valids_after", bus.xbar_ch_rtn_valid_o, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
